// File: rtl/wave_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wave_rom_arbiter
//  Purpose  : Round-robin sharing of one byte-wide wave ROM/DDR read port
//             between NUM_PORTS sample players, one read outstanding.
//  Revision : 1.0  initial release
// ============================================================================
module wave_rom_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 28,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]        req_rd,
    output logic [NUM_PORTS*8-1:0]      req_data,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rd,
    input  logic                        mem_busy,
    input  logic [7:0]                  mem_data,
    input  logic                        mem_valid,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                        timeout
);

    localparam int c_gw = $clog2(NUM_PORTS);
    localparam int c_tw = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_tw-1:0] c_tlim = c_tw'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;

    logic [1:0]           r_state;
    logic [ADDR_W-1:0]    r_addr [NUM_PORTS];
    logic [7:0]           r_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_pending;
    logic [NUM_PORTS-1:0] r_ready;
    logic [c_gw-1:0]      r_grant;
    logic [c_gw-1:0]      r_last;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_rd;
    logic [c_tw-1:0]      r_cnt;
    logic                 r_timeout;

    logic [c_gw-1:0]      w_cand [NUM_PORTS];
    logic [c_gw-1:0]      w_pick;
    logic                 w_tmo;
    logic                 w_done;

    // w_cand[k] is the k-th port after the last grant, wrapping.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_cand
        assign w_cand[k] = c_gw'((int'(r_last) + k + 1) % NUM_PORTS);
    end

    always_comb begin
        w_pick = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (r_pending[w_cand[k]]) begin
                w_pick = w_cand[k];
            end
        end
    end

    assign w_tmo  = (TIMEOUT != 0) && (r_cnt == c_tlim);
    assign w_done = (r_state == c_wait) && (mem_valid || w_tmo);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_pending  <= '0;
            r_ready    <= '1;
            r_grant    <= '0;
            r_last     <= c_gw'(NUM_PORTS - 1);
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            case (r_state)
                c_idle: begin
                    if (|r_pending) begin
                        r_grant    <= w_pick;
                        r_mem_addr <= r_addr[w_pick];
                        r_mem_rd   <= 1'b1;
                        r_state    <= c_issue;
                    end
                end
                c_issue: begin
                    if (!mem_busy) begin
                        r_mem_rd <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= c_wait;
                    end
                end
                c_wait: begin
                    if (w_done) begin
                        // A timed-out read completes with a zero byte so the player never stalls.
                        r_data[r_grant]    <= mem_valid ? mem_data : 8'h00;
                        r_pending[r_grant] <= 1'b0;
                        r_ready[r_grant]   <= 1'b1;
                        r_last             <= r_grant;
                        r_state            <= c_idle;
                        if (!mem_valid) begin
                            r_timeout <= 1'b1;
                        end
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + c_tw'(1);
                    end
                end
                default: r_state <= c_idle;
            endcase

            // Capture never collides with completion: the completing port has READY low.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_rd[i] && r_ready[i]) begin
                    r_addr[i]    <= req_addr[i*ADDR_W +: ADDR_W];
                    r_pending[i] <= 1'b1;
                    r_ready[i]   <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_out
        assign req_data[i*8 +: 8] = r_data[i];
    end

    assign req_ready = r_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign grant     = r_grant;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wave_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wave_rom_arbiter
//  Purpose  : Self-checking bench: vector table, corner sequences and a
//             randomized player/memory run against a round-robin model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wave_rom_arbiter;

    localparam int NP = 4;
    localparam int AW = 28;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP-1:0]   req_rd = '0;
    logic [NP*8-1:0] req_data;
    logic [NP-1:0]   req_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic            mem_busy = 1'b0;
    logic [7:0]      mem_data = '0;
    logic            mem_valid = 1'b0;
    logic [1:0]      grant;
    logic            timeout;

    always #5 clk = ~clk;

    wave_rom_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_rd(req_rd),
        .req_data(req_data), .req_ready(req_ready),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_busy(mem_busy),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .grant(grant), .timeout(timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[19:12];
    endfunction

    function automatic int rr(input int last, input bit [NP-1:0] s);
        for (int k = 1; k <= NP; k++) begin
            if (s[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    // ---------------- memory responder ----------------
    int         lat_cfg = 1;
    int         busy_cfg = 0;
    bit         rnd_mode = 0;
    bit         spur_en = 0;
    bit         drop_next = 0;
    bit         force_en = 0;
    logic [7:0] force_val = '0;
    int         pend_cnt = 0;
    int         busy_left = 0;
    bit         rd_prev = 0;
    logic [7:0] resp = '0;
    int         n_accept = 0;
    int         overlap_err = 0;
    logic [AW-1:0] acc_addr = '0;
    int         acc_q[$];

    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = resp;
            end
        end else if (spur_en && $urandom_range(0, 9) == 0) begin
            mem_valid = 1'b1;
            mem_data  = 8'hEE;
        end
        if (mem_rd && !rd_prev) busy_left = rnd_mode ? int'($urandom_range(0, 3)) : busy_cfg;
        rd_prev  = mem_rd;
        mem_busy = mem_rd && (busy_left > 0);
        if (mem_busy) busy_left--;
        if (mem_rd && !mem_busy) begin
            if (pend_cnt > 0) overlap_err++;
            n_accept++;
            acc_addr = mem_addr;
            acc_q.push_back(int'(grant));
            resp = force_en ? force_val : mem_byte(mem_addr);
            if (drop_next) begin
                drop_next = 0;
                pend_cnt  = 0;
            end else begin
                pend_cnt = rnd_mode ? int'($urandom_range(1, 4)) : lat_cfg;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", req_ready, 4'hF);
        check("rst_timeout", timeout, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_grant", grant, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         port;
        logic [AW-1:0] addr;
        bit         fen;
        logic [7:0] fval;
        int         busy;
        int         lat;
        bit         drop;
        logic [7:0] exp_data;
        int         exp_n;
        int         exp_rd;
        bit         exp_to;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, rdc, acc0, guard;
        bit [NP-1:0] m_pend, snap, rd_drv, rdy_prev;
        logic [7:0]  m_exp [NP];
        logic [AW-1:0] m_addr [NP];
        logic [AW-1:0] addr_drv [NP];
        int m_last, n_done, exp_g;
        bit mrd_prev;

        tbl[0] = '{0, 28'h0000100, 1, 8'h5A, 0, 1, 0, 8'h5A,  4, 1, 0};
        tbl[1] = '{1, 28'h0012345, 0, 8'h00, 0, 3, 0, 8'h57,  6, 1, 0};
        tbl[2] = '{2, 28'hABCDEF0, 1, 8'h33, 5, 2, 0, 8'h33, 10, 6, 0};
        tbl[3] = '{3, 28'h0000FFF, 0, 8'h00, 2, 1, 0, 8'hFF,  6, 3, 0};
        tbl[4] = '{1, 28'h0000200, 1, 8'h99, 0, 1, 1, 8'h00, 11, 1, 1};
        tbl[5] = '{1, 28'h0F0F0F0, 1, 8'hC3, 1, 4, 0, 8'hC3,  8, 2, 1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("init_ready", req_ready, 4'hF);
        check("init_data", req_data, 0);
        check("init_mem_rd", mem_rd, 0);
        check("init_mem_addr", mem_addr, 0);
        check("init_grant", grant, 0);
        check("init_timeout", timeout, 0);

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            force_en  = tbl[v].fen;
            force_val = tbl[v].fval;
            busy_cfg  = tbl[v].busy;
            lat_cfg   = tbl[v].lat;
            drop_next = tbl[v].drop;
            acc0      = n_accept;
            req_addr[tbl[v].port*AW +: AW] = tbl[v].addr;
            req_rd[tbl[v].port] = 1'b1;
            @(negedge clk);
            req_rd = '0;
            n   = 1;
            rdc = mem_rd ? 1 : 0;
            while (!req_ready[tbl[v].port] && n < 40) begin
                @(negedge clk);
                n++;
                if (mem_rd) rdc++;
            end
            check($sformatf("vec%0d_latency", v), n, tbl[v].exp_n);
            check($sformatf("vec%0d_data", v), req_data[tbl[v].port*8 +: 8], tbl[v].exp_data);
            check($sformatf("vec%0d_rd_cycles", v), rdc, tbl[v].exp_rd);
            check($sformatf("vec%0d_accepts", v), n_accept - acc0, 1);
            check($sformatf("vec%0d_addr", v), acc_addr, tbl[v].addr);
            check($sformatf("vec%0d_timeout", v), timeout, tbl[v].exp_to);
            repeat (2) @(negedge clk);
        end
        check("tbl_port0_hold", req_data[7:0], 8'h5A);
        force_en = 0;
        busy_cfg = 0;
        lat_cfg  = 1;

        // ---- all four ports request on one edge ----
        do_reset();
        acc_q.delete();
        for (int i = 0; i < NP; i++) req_addr[i*AW +: AW] = AW'(32'h10 * i);
        req_rd = '1;
        @(negedge clk);
        req_rd = '0;
        guard = 0;
        while (req_ready != 4'hF && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        check("all4_done", req_ready, 4'hF);
        check("all4_grants", acc_q.size(), 4);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("all4_order%0d", i), (acc_q.size() > i) ? acc_q[i] : -1, i);
            check($sformatf("all4_data%0d", i), req_data[i*8 +: 8], 8'(8'h10 * i));
        end
        check("all4_overlap", overlap_err, 0);

        // ---- timeout on port 1, port 2 served next ----
        acc_q.delete();
        drop_next = 1;
        @(negedge clk);
        req_addr[1*AW +: AW] = 28'h0000021;
        req_addr[2*AW +: AW] = 28'h0005A32;
        req_rd = 4'b0110;
        @(negedge clk);
        req_rd = '0;
        guard = 0;
        while (req_ready != 4'hF && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        check("tmo_done", req_ready, 4'hF);
        check("tmo_first_grant", (acc_q.size() > 0) ? acc_q[0] : -1, 1);
        check("tmo_second_grant", (acc_q.size() > 1) ? acc_q[1] : -1, 2);
        check("tmo_data1", req_data[15:8], 8'h00);
        check("tmo_data2", req_data[23:16], 8'h37);
        check("tmo_sticky", timeout, 1);
        repeat (3) @(negedge clk);
        check("tmo_still_sticky", timeout, 1);

        // ---- reset in WAIT, stale valid afterwards ----
        do_reset();
        lat_cfg = 6;
        acc0 = n_accept;
        req_addr[3*AW +: AW] = 28'h0000123;
        req_rd[3] = 1'b1;
        @(negedge clk);
        req_rd = '0;
        guard = 0;
        while (n_accept == acc0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rstwait_accepted", n_accept - acc0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstwait_ready", req_ready, 4'hF);
        check("rstwait_mem_rd", mem_rd, 0);
        rdc = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd) rdc++;
        end
        check("rstwait_no_reissue", rdc, 0);
        check("rstwait_stale_ignored", req_data[31:24], 8'h00);
        check("rstwait_ready_after", req_ready, 4'hF);
        lat_cfg = 1;

        // ---- randomized players against a round-robin model ----
        rnd_mode = 1;
        spur_en  = 1;
        m_pend   = '0;
        m_last   = NP - 1;
        n_done   = 0;
        rd_drv   = '0;
        rdy_prev = req_ready;
        mrd_prev = mem_rd;
        for (int i = 0; i < NP; i++) begin
            m_exp[i] = '0;
            m_addr[i] = '0;
            addr_drv[i] = '0;
        end
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            snap = m_pend;
            if (mem_rd && !mrd_prev) begin
                exp_g = rr(m_last, snap);
                check("rand_grant", grant, exp_g);
                if (exp_g >= 0) check("rand_addr", mem_addr, m_addr[exp_g]);
            end
            for (int i = 0; i < NP; i++) begin
                if (!rdy_prev[i] && req_ready[i]) begin
                    check("rand_data", req_data[i*8 +: 8], m_exp[i]);
                    m_pend[i] = 1'b0;
                    m_last    = i;
                    n_done++;
                end
                if (rd_drv[i] && rdy_prev[i]) begin
                    check("rand_capture_ready", req_ready[i], 0);
                    m_pend[i] = 1'b1;
                    m_addr[i] = addr_drv[i];
                    m_exp[i]  = mem_byte(addr_drv[i]);
                end
            end
            rdy_prev = req_ready;
            mrd_prev = mem_rd;
            for (int i = 0; i < NP; i++) begin
                addr_drv[i] = AW'($urandom);
                rd_drv[i]   = req_ready[i] && ($urandom_range(0, 3) == 0);
                req_addr[i*AW +: AW] = addr_drv[i];
                req_rd[i] = rd_drv[i] | (!req_ready[i] && ($urandom_range(0, 1) == 0));
            end
        end
        req_rd = '0;
        check("rand_progress", (n_done >= 300) ? 1 : 0, 1);
        check("rand_overlap", overlap_err, 0);
        check("rand_no_timeout", timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
